// File: rtl/sd_crc_pkg.sv
// Shared types and constants for the SD CRC engine (CRC7 on CMD, CRC16 on DAT).
// The CHECK state is only present when SD_CRC_CHECK_EN is defined.
package sd_crc_pkg;

`ifdef SD_CRC_CHECK_EN
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DONE  = 2'd2,
        ST_CHECK = 2'd3
    } state_e;
`else
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DONE  = 2'd2
    } state_e;
`endif

    localparam logic [6:0]  CRC7_POLY  = 7'h09;
    localparam logic [15:0] CRC16_POLY = 16'h1021;

    // Width of a word counter able to hold 0..max_len inclusive.
    function automatic int len_w(input int max_len);
        return $clog2(max_len + 1);
    endfunction

endpackage

// File: rtl/sd_crc_engine_if.sv
// Frame/stream/check bundle between the SD shifters and the CRC engine.
interface sd_crc_engine_if #(
    parameter int CRC_W  = 7,
    parameter int DATA_W = 8,
    parameter int LEN_W  = 10
);
    logic              start;
    logic [LEN_W-1:0]  len;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              busy;
    logic              crc_valid;
    logic [CRC_W-1:0]  crc_out;
    logic              chk_valid;
    logic [CRC_W-1:0]  chk_crc;
    logic              chk_done;
    logic              chk_err;

    modport master (
        output start, len, in_valid, in_data, chk_valid, chk_crc,
        input  in_ready, busy, crc_valid, crc_out, chk_done, chk_err
    );

    modport slave (
        input  start, len, in_valid, in_data, chk_valid, chk_crc,
        output in_ready, busy, crc_valid, crc_out, chk_done, chk_err
    );
endinterface

// File: rtl/sd_crc_step.sv
// One DATA_W-bit CRC update, MSB first, unrolled; shared with the CMD/DAT shifters.
module sd_crc_step #(
    parameter int               CRC_W  = 7,
    parameter logic [CRC_W-1:0] POLY   = 7'h09,
    parameter int               DATA_W = 8
) (
    input  logic [CRC_W-1:0]  crc_in,
    input  logic [DATA_W-1:0] data_in,
    output logic [CRC_W-1:0]  crc_out
);

    logic [CRC_W-1:0] acc_s;
    logic             fb_s;

    // Serial LFSR update, one iteration per data bit.
    always_comb begin
        acc_s = crc_in;
        fb_s  = 1'b0;
        for (int i = DATA_W - 1; i >= 0; i--) begin
            fb_s  = acc_s[CRC_W-1] ^ data_in[i];
            acc_s = {acc_s[CRC_W-2:0], 1'b0} ^ (fb_s ? POLY : {CRC_W{1'b0}});
        end
        crc_out = acc_s;
    end

endmodule

// File: rtl/sd_crc_engine.sv
// Streaming length-framed CRC generator/checker (CRC7 or CRC16).
// Define SD_CRC_CHECK_EN to build the received-CRC comparison (CHECK state).
module sd_crc_engine
    import sd_crc_pkg::*;
#(
    parameter int               CRC_W   = 7,
    parameter logic [CRC_W-1:0] POLY    = CRC7_POLY,
    parameter int               DATA_W  = 8,
    parameter int               MAX_LEN = 512,
    parameter logic [CRC_W-1:0] INIT    = {CRC_W{1'b0}}
) (
    input  logic            clk,
    input  logic            rst,
    sd_crc_engine_if.slave  bus
);

    localparam int LEN_W = len_w(MAX_LEN);
    localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] ONE_L     = LEN_W'(1);

    state_e           state_q, state_d;
    logic [CRC_W-1:0] crc_q, crc_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic             in_ready_q, in_ready_d;
    logic             busy_q, busy_d;
    logic             crc_valid_q, crc_valid_d;
    logic [LEN_W-1:0] len_sat_s;
    logic [CRC_W-1:0] step_crc_s;
    logic             beat_s;

    sd_crc_step #(
        .CRC_W  (CRC_W),
        .POLY   (POLY),
        .DATA_W (DATA_W)
    ) u_step (
        .crc_in  (crc_q),
        .data_in (bus.in_data),
        .crc_out (step_crc_s)
    );

    assign len_sat_s = (bus.len > MAX_LEN_L) ? MAX_LEN_L : bus.len;
    // in_ready_q mirrors state RUN, so this is the accepted-beat strobe.
    assign beat_s    = in_ready_q & bus.in_valid;

`ifdef SD_CRC_CHECK_EN
    logic chk_err_q, chk_err_d;
    logic chk_done_q, chk_done_d;
`else
    logic unused_chk_s;
    assign unused_chk_s = ^{bus.chk_valid, bus.chk_crc};
`endif

    // Next-state, datapath and next-output decode; start overrides every state.
    always_comb begin
        state_d = state_q;
        crc_d   = crc_q;
        cnt_d   = cnt_q;
`ifdef SD_CRC_CHECK_EN
        chk_err_d  = chk_err_q;
        chk_done_d = 1'b0;
`endif
        if (bus.start) begin
            crc_d   = INIT;
            cnt_d   = len_sat_s;
            state_d = (len_sat_s == {LEN_W{1'b0}}) ? ST_DONE : ST_RUN;
`ifdef SD_CRC_CHECK_EN
            chk_err_d = 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_IDLE;
                end
                ST_RUN: begin
                    if (beat_s) begin
                        crc_d = step_crc_s;
                        cnt_d = cnt_q - ONE_L;
                        if (cnt_q == ONE_L) begin
                            state_d = ST_DONE;
                        end else begin
                            state_d = ST_RUN;
                        end
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                ST_DONE: begin
`ifdef SD_CRC_CHECK_EN
                    state_d = ST_CHECK;
`else
                    state_d = ST_IDLE;
`endif
                end
`ifdef SD_CRC_CHECK_EN
                ST_CHECK: begin
                    if (bus.chk_valid) begin
                        chk_err_d  = (bus.chk_crc != crc_q);
                        chk_done_d = 1'b1;
                        state_d    = ST_IDLE;
                    end else begin
                        state_d = ST_CHECK;
                    end
                end
`endif
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
        in_ready_d  = (state_d == ST_RUN);
        busy_d      = (state_d != ST_IDLE);
        crc_valid_d = (state_d == ST_DONE);
    end

    // State, datapath and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            crc_q       <= INIT;
            cnt_q       <= {LEN_W{1'b0}};
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
            crc_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            crc_q       <= crc_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
            crc_valid_q <= crc_valid_d;
        end
    end

`ifdef SD_CRC_CHECK_EN
    // Check result flops; chk_err is held until the next start.
    always_ff @(posedge clk) begin
        if (rst) begin
            chk_err_q  <= 1'b0;
            chk_done_q <= 1'b0;
        end else begin
            chk_err_q  <= chk_err_d;
            chk_done_q <= chk_done_d;
        end
    end

    assign bus.chk_err  = chk_err_q;
    assign bus.chk_done = chk_done_q;
`else
    assign bus.chk_err  = 1'b0;
    assign bus.chk_done = 1'b0;
`endif

    assign bus.in_ready  = in_ready_q;
    assign bus.busy      = busy_q;
    assign bus.crc_valid = crc_valid_q;
    assign bus.crc_out   = crc_q;

endmodule

// File: doc/sd_crc_engine.md
# sd_crc_engine

Parametrised, streaming CRC generator/checker for the SD card path, replacing the fixed 256×8 CRC7 lookup table with a single engine covering both CRC7 (CMD line) and CRC16 (DAT lines). It accepts a length-framed stream of data words over a valid/ready handshake and updates the CRC once per accepted word. At end of frame it presents the final CRC and, optionally, compares it against a received CRC. It sits between the SD command/data shifters and the sdcard_top controller FSM.

## Interface
Parameters:
- CRC_W, 7, CRC width in bits (7 or 16 used; any 3..32 legal)
- POLY, 7'h09, generator polynomial without the implicit x^CRC_W term (CRC16 uses 16'h1021)
- DATA_W, 8, input word width, 1..32
- MAX_LEN, 512, maximum number of words per frame
- INIT, 0, CRC register value loaded on start

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  one-cycle pulse: load INIT, latch len, begin frame
- len  in  LEN_W = $clog2(MAX_LEN+1)  word count of the frame, sampled on start
- in_valid  in  1  data word valid
- in_data  in  DATA_W  data word, MSB transmitted first
- in_ready  out  1  engine accepts a word this cycle
- busy  out  1  frame in progress (any state except IDLE)
- crc_valid  out  1  one-cycle pulse, crc_out is final
- crc_out  out  CRC_W  CRC register contents
- chk_valid  in  1  received CRC present
- chk_crc  in  CRC_W  received CRC
- chk_done  out  1  one-cycle pulse, chk_err valid
- chk_err  out  1  received CRC mismatched; held until next start

## Operation
- States: IDLE, RUN, DONE, CHECK (CHECK exists only with SD_CRC_CHECK_EN).
- IDLE: in_ready=0. On start, crc<=INIT, cnt<=len, chk_err<=0; go to RUN, or to DONE if len==0.
- RUN: in_ready=1. A beat is in_valid&&in_ready. Each beat: crc<=step(crc,in_data), cnt<=cnt-1; the beat with cnt==1 moves to DONE.
- step: for each of the DATA_W bits, MSB first: fb=crc[CRC_W-1]^bit; crc={crc[CRC_W-2:0],1'b0}^(fb?POLY:0). All arithmetic modulo 2, width CRC_W.
- DONE: crc_valid=1 for exactly one cycle. Next state is CHECK with the macro, IDLE without it.
- CHECK: wait for chk_valid. When it arrives, chk_err<=(chk_crc!=crc), chk_done=1 for one cycle, then go to IDLE.
- crc_out holds its final value until the next start.
- start has priority in every state: it aborts the current frame and restarts. A beat presented in the same cycle as start is not consumed.
- len>MAX_LEN: saturate to MAX_LEN.
- in_valid outside RUN is ignored.

## Timing
- Reset values: state IDLE, crc_out=INIT, in_ready=0, busy=0, crc_valid=0, chk_done=0, chk_err=0.
- start in cycle t gives busy=1 and in_ready=1 at t+1.
- One word per cycle throughput. Back-to-back beats are allowed.
- Last beat accepted at cycle t gives crc_valid=1 at t+1, with crc_out already final.
- len==0: start at t gives crc_valid at t+1 and crc_out=INIT.
- chk_valid sampled at t gives chk_done at t+1. A chk_valid asserted during the DONE cycle is not sampled.
- A new start is accepted in the cycle after crc_valid (non-check builds) or after chk_done (check builds).
- Reset mid-frame returns to the reset values in the next cycle. No partial crc_valid is emitted.

## Configuration
- SD_CRC_CHECK_EN defined:
  - CHECK state and the comparison logic are built.
  - Every frame must be closed by chk_valid or by a start.
- SD_CRC_CHECK_EN undefined:
  - CHECK state is removed.
  - chk_valid and chk_crc are ignored.
  - chk_done and chk_err are tied to 0.
  - DONE returns straight to IDLE.

## Structure
- sd_crc_pkg holds:
  - state enum
  - CRC7_POLY=7'h09 and CRC16_POLY=16'h1021
  - the LEN_W helper function
- sd_crc_step: combinational sub-module, parametrised by CRC_W, POLY and DATA_W. It implements one DATA_W-bit update via an unrolled loop and is reused by the command and data shifters.

## Test plan
- CRC7, DATA_W=8, len=5, bytes 40 00 00 00 00 (CMD0) -> crc_valid one cycle after the 5th beat, crc_out=7'h4A.
- CRC7, bytes 48 00 00 01 AA (CMD8) -> crc_out=7'h43. With SD_CRC_CHECK_EN, chk_crc=7'h43 -> chk_done with chk_err=0; chk_crc=7'h42 -> chk_err=1.
- CRC16, POLY=16'h1021, len=512, all bytes FF, in_valid toggled randomly -> crc_out=16'h7FA1, exactly 512 beats consumed.
- len=0 -> crc_valid at start+1 with crc_out=INIT. start re-issued at beat 3 of a CMD8 frame, then CMD0 sent -> crc_out=7'h4A.
- rst asserted mid-frame -> all outputs at reset values next cycle, no crc_valid. DATA_W=1 bitwise CMD0 (40 bits) -> crc_out=7'h4A.
